// File: rtl/babbage_result_display_if.sv
// Handshake between the difference engine and the result display:
// the engine drives a result with a one-cycle strobe, the display reports conversion status.
interface babbage_result_display_if;
  logic [9:0] result;
  logic       done_tick;
  logic       busy;
  logic       conv_done;

  modport master (
    output result,
    output done_tick,
    input  busy,
    input  conv_done
  );

  modport slave (
    input  result,
    input  done_tick,
    output busy,
    output conv_done
  );
endinterface

// File: rtl/babbage_result_display.sv
// Captures a signed engine result, converts |result| to BCD by sequential double-dabble,
// and scans sign/hundreds/tens/ones onto a 4-digit active-low seven-segment display.
module babbage_result_display #(
  parameter int SCAN_DIV      = 16,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  babbage_result_display_if.slave         eng,
  output logic [3:0]                      an_o,
  output logic [6:0]                      seg_o,
  output logic                            dp_o
);

  localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_MINUS = 7'b0111111;
  localparam logic [3:0]     ITER_LAST = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on each nibble; the hundreds carry into bit 11 is shifted out next step anyway.
  function automatic logic [10:0] dabble_adj(input logic [11:0] b);
    logic [2:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = b[10:8] + ((b[11:8] >= 4'd5) ? 3'd3 : 3'd0);
    t = b[7:4]  + ((b[7:4]  >= 4'd5) ? 4'd3 : 4'd0);
    o = b[3:0]  + ((b[3:0]  >= 4'd5) ? 4'd3 : 4'd0);
    return {h, t, o};
  endfunction

  state_e        state_q, state_d;
  logic [10:0]   mag_q, mag_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [3:0]    iter_q, iter_d;
  logic          sign_q, sign_d;
  logic          busy_q, busy_d;
  logic          conv_done_q, conv_done_d;
  logic          disp_sign_q, disp_sign_d;
  logic [11:0]   disp_bcd_q, disp_bcd_d;
  logic          disp_valid_q, disp_valid_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [10:0]   ext_s;
  logic [10:0]   abs_s;
  logic [10:0]   adj_s;
  logic          h_blank_s;
  logic          t_blank_s;

  assign ext_s = {eng.result[9], eng.result};
  assign abs_s = eng.result[9] ? (11'd0 - ext_s) : ext_s;
  assign adj_s = dabble_adj(bcd_q);

  // Before the first conversion the leading digits stay dark regardless of the blanking mode.
  assign h_blank_s = !disp_valid_q || (BLANK_LEADING && (disp_bcd_q[11:8] == 4'd0));
  assign t_blank_s = !disp_valid_q ||
                     (BLANK_LEADING && (disp_bcd_q[11:8] == 4'd0) && (disp_bcd_q[7:4] == 4'd0));

  // Conversion FSM: capture, double-dabble shifting, commit to display registers.
  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    sign_d       = sign_q;
    disp_sign_d  = disp_sign_q;
    disp_bcd_d   = disp_bcd_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      IDLE: begin
        if (eng.done_tick) begin
          sign_d  = eng.result[9];
          mag_d   = abs_s;
          bcd_d   = 12'd0;
          iter_d  = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d = {adj_s, mag_q[10]};
        mag_d = {mag_q[9:0], 1'b0};
        if (iter_q == ITER_LAST) begin
          state_d = COMMIT;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      COMMIT: begin
        disp_sign_d  = sign_q;
        disp_bcd_d   = bcd_q;
        disp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    conv_done_d = (state_d == COMMIT);
  end

  // Digit scan: advance the digit on counter wrap and load an/seg together.
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    an_d   = an_q;
    seg_d  = seg_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = {CW{1'b0}};
      idx_d  = idx_q + 2'd1;
      case (idx_d)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = seg_of(disp_bcd_q[3:0]);
        end
        2'd1: begin
          an_d  = 4'b1101;
          seg_d = t_blank_s ? SEG_BLANK : seg_of(disp_bcd_q[7:4]);
        end
        2'd2: begin
          an_d  = 4'b1011;
          seg_d = h_blank_s ? SEG_BLANK : seg_of(disp_bcd_q[11:8]);
        end
        2'd3: begin
          an_d  = 4'b0111;
          seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
        end
        default: begin
          an_d  = 4'b1110;
          seg_d = SEG_BLANK;
        end
      endcase
    end else begin
      scan_d = scan_q + CW'(1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mag_q        <= 11'd0;
      bcd_q        <= 12'd0;
      iter_q       <= 4'd0;
      sign_q       <= 1'b0;
      busy_q       <= 1'b0;
      conv_done_q  <= 1'b0;
      disp_sign_q  <= 1'b0;
      disp_bcd_q   <= 12'd0;
      disp_valid_q <= 1'b0;
      scan_q       <= {CW{1'b0}};
      idx_q        <= 2'd0;
      an_q         <= 4'b1110;
      seg_q        <= 7'b1000000;
    end else begin
      state_q      <= state_d;
      mag_q        <= mag_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      sign_q       <= sign_d;
      busy_q       <= busy_d;
      conv_done_q  <= conv_done_d;
      disp_sign_q  <= disp_sign_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_valid_q <= disp_valid_d;
      scan_q       <= scan_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign eng.busy      = busy_q;
  assign eng.conv_done = conv_done_q;
  assign an_o          = an_q;
  assign seg_o         = seg_q;
  assign dp_o          = 1'b1;

endmodule

// File: tb/tb_babbage_result_display.sv
// Bench for babbage_result_display: two instances (leading-zero blanking on/off) fed the same results,
// checked against vector tables and a decimal-arithmetic model of the display.
module tb_babbage_result_display;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;

  typedef struct {
    logic [9:0] res;
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
    logic [6:0] b2;
    logic [6:0] b1;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] res = 10'd0;
  logic       dt = 1'b0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] codes [10];
  vec_t       vecs [8];

  logic m_sign;
  int   m_mag;
  bit   m_valid;

  babbage_result_display_if if_a ();
  babbage_result_display_if if_b ();

  assign if_a.result    = res;
  assign if_a.done_tick = dt;
  assign if_b.result    = res;
  assign if_b.done_tick = dt;

  babbage_result_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .reset(reset), .eng(if_a.slave), .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a)
  );

  babbage_result_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .reset(reset), .eng(if_b.slave), .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] model_digit(input bit blank_leading, input int pos);
    int h, t, o;
    h = m_mag / 100;
    t = (m_mag / 10) % 10;
    o = m_mag % 10;
    case (pos)
      3: return m_sign ? MINUS : BLANK;
      2: return (!m_valid || (blank_leading && h == 0)) ? BLANK : codes[h];
      1: return (!m_valid || (blank_leading && h == 0 && t == 0)) ? BLANK : codes[t];
      default: return codes[o];
    endcase
  endfunction

  function automatic void model_accept(input logic [9:0] v);
    int s;
    s = $signed(v);
    m_sign  = v[9];
    m_mag   = (s < 0) ? -s : s;
    m_valid = 1'b1;
  endfunction

  task automatic collect(input bit inst, input string tag, output logic [3:0][6:0] d);
    logic [3:0] a;
    logic [6:0] s;
    logic [3:0] seen;
    bit         bad;
    seen = 4'h0;
    bad  = 1'b0;
    d    = '0;
    repeat (24) begin
      @(negedge clk);
      a = inst ? an_b : an_a;
      s = inst ? seg_b : seg_a;
      if ($countones(~a) != 1) bad = 1'b1;
      case (a)
        4'b1110: begin d[0] = s; seen[0] = 1'b1; end
        4'b1101: begin d[1] = s; seen[1] = 1'b1; end
        4'b1011: begin d[2] = s; seen[2] = 1'b1; end
        4'b0111: begin d[3] = s; seen[3] = 1'b1; end
        default: bad = 1'b1;
      endcase
    end
    chk($sformatf("%s_onehot_an%0d", tag, inst), {31'd0, bad}, 32'd0);
    chk($sformatf("%s_digits_seen%0d", tag, inst), {28'd0, seen}, 32'hF);
  endtask

  task automatic check_display(input string tag);
    logic [3:0][6:0] d;
    repeat (16) @(negedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      collect(inst[0], tag, d);
      for (int p = 0; p < 4; p++)
        chk($sformatf("%s_inst%0d_digit%0d", tag, inst, p), {25'd0, d[p]},
            {25'd0, model_digit(inst == 0, p)});
    end
  endtask

  // Pulse done_tick with v; optionally issue a second strobe at offset sp (must be ignored).
  task automatic convert(input string tag, input logic [9:0] v, input int sp, input logic [9:0] spv);
    @(negedge clk);
    res = v;
    dt  = 1'b1;
    @(negedge clk);
    for (int j = 0; j <= 13; j++) begin
      chk($sformatf("%s_busy_t%0d", tag, j), {31'd0, if_a.busy}, {31'd0, j <= 11});
      chk($sformatf("%s_conv_done_t%0d", tag, j), {31'd0, if_a.conv_done}, {31'd0, j == 11});
      dt  = (j == sp);
      res = (j == sp) ? spv : v;
      @(negedge clk);
    end
    dt = 1'b0;
    model_accept(v);
  endtask

  initial begin
    logic [3:0][6:0] d;
    int              cd_seen;
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0] = '{10'd5,   BLANK, BLANK, BLANK, 7'h12, 7'h40, 7'h40};
    vecs[1] = '{10'h200, MINUS, 7'h12, 7'h79, 7'h24, 7'h12, 7'h79};
    vecs[2] = '{10'd40,  BLANK, BLANK, 7'h19, 7'h40, 7'h40, 7'h19};
    vecs[3] = '{10'd0,   BLANK, BLANK, BLANK, 7'h40, 7'h40, 7'h40};
    vecs[4] = '{10'd511, BLANK, 7'h12, 7'h79, 7'h79, 7'h12, 7'h79};
    vecs[5] = '{10'h3FF, MINUS, BLANK, BLANK, 7'h79, 7'h40, 7'h40};
    vecs[6] = '{10'd100, BLANK, 7'h79, 7'h40, 7'h40, 7'h79, 7'h40};
    vecs[7] = '{10'h397, MINUS, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40};
    m_sign  = 1'b0;
    m_mag   = 0;
    m_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_an", {28'd0, an_a}, 32'hE);
    chk("reset_seg", {25'd0, seg_a}, 32'h40);
    chk("reset_busy", {31'd0, if_a.busy}, 32'd0);
    chk("reset_conv_done", {31'd0, if_a.conv_done}, 32'd0);
    chk("reset_dp", {30'd0, dp_a, dp_b}, 32'd3);
    chk("reset_an_b", {28'd0, an_b}, 32'hE);
    reset = 1'b0;

    // Scan sequence after reset: digit k/4, only the ones digit lit with '0'
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("scan_an_k%0d", k), {28'd0, an_a}, {28'd0, ~(4'b0001 << ((k / 4) % 4))});
      chk($sformatf("scan_seg_k%0d", k), {25'd0, seg_a}, ((k / 4) % 4 == 0) ? 32'h40 : 32'h7F);
    end
    check_display("reset_display");

    // Table-driven conversions
    for (int i = 0; i < 8; i++) begin
      convert($sformatf("vec%0d", i), vecs[i].res, -1, 10'd0);
      repeat (16) @(negedge clk);
      collect(1'b0, $sformatf("vec%0d", i), d);
      chk($sformatf("vec%0d_A_d3", i), {25'd0, d[3]}, {25'd0, vecs[i].d3});
      chk($sformatf("vec%0d_A_d2", i), {25'd0, d[2]}, {25'd0, vecs[i].d2});
      chk($sformatf("vec%0d_A_d1", i), {25'd0, d[1]}, {25'd0, vecs[i].d1});
      chk($sformatf("vec%0d_A_d0", i), {25'd0, d[0]}, {25'd0, vecs[i].d0});
      collect(1'b1, $sformatf("vec%0d", i), d);
      chk($sformatf("vec%0d_B_d3", i), {25'd0, d[3]}, {25'd0, vecs[i].d3});
      chk($sformatf("vec%0d_B_d2", i), {25'd0, d[2]}, {25'd0, vecs[i].b2});
      chk($sformatf("vec%0d_B_d1", i), {25'd0, d[1]}, {25'd0, vecs[i].b1});
      chk($sformatf("vec%0d_B_d0", i), {25'd0, d[0]}, {25'd0, vecs[i].d0});
    end

    // Second strobe 4 cycles after the first is dropped; a later 7 converts
    convert("drop255", 10'd255, 3, 10'd7);
    check_display("drop255");
    convert("seven", 10'd7, -1, 10'd0);
    check_display("seven");

    // Reset during cycle t+6 of a conversion aborts it
    @(negedge clk);
    res = 10'd300;
    dt  = 1'b1;
    @(negedge clk);
    dt = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, if_a.busy}, 32'd0);
    chk("abort_conv_done", {31'd0, if_a.conv_done}, 32'd0);
    chk("abort_an", {28'd0, an_a}, 32'hE);
    chk("abort_seg", {25'd0, seg_a}, 32'h40);
    cd_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (if_a.conv_done || if_b.conv_done) cd_seen++;
    end
    chk("abort_no_conv_done", cd_seen, 0);
    m_sign  = 1'b0;
    m_mag   = 0;
    m_valid = 1'b0;
    check_display("abort_display");
    convert("after_abort", 10'd123, -1, 10'd0);
    check_display("after_abort");

    // Randomized results, some with a spurious strobe during the conversion
    for (int r = 0; r < 12; r++) begin
      logic [9:0] v, sv;
      int         sp;
      v  = 10'($urandom_range(0, 1023));
      sv = 10'($urandom_range(0, 1023));
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : -1;
      convert($sformatf("rand%0d", r), v, sp, sv);
      check_display($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
